// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int unsigned MD_ITERS = 32;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIXUP,
        DONE
    } md_state_e;

    // Two's-complement negate when neg is set; narrower values are zero-extended by the caller.
    function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide,
// 32 iterations, result returned over a valid/ready pair.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    md_state_e         state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div, a_signed, b_signed, sgn_a, sgn_b;
    logic [2*XLEN-1:0] neg_a, neg_b, prod_fix, quo_fix, rem_fix;
    logic [XLEN:0]     r33, addsub;
    logic              unused_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        is_div   = op_q[2];
        a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
        b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        sgn_a    = a_signed & acc_q[XLEN-1];
        sgn_b    = b_signed & opb_q[XLEN-1];
        neg_a    = cond_neg({{XLEN{1'b0}}, acc_q[XLEN-1:0]}, sgn_a);
        neg_b    = cond_neg({{XLEN{1'b0}}, opb_q}, sgn_b);

        // Multiply adds into the upper half; divide trial-subtracts from the shifted remainder.
        r33      = is_div ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
        addsub   = is_div ? (r33 - {1'b0, opb_q}) : (r33 + {1'b0, opb_q});

        prod_fix = cond_neg(acc_q, neg_q);
        quo_fix  = cond_neg({{XLEN{1'b0}}, acc_q[XLEN-1:0]}, neg_q);
        rem_fix  = cond_neg({{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]}, neg_q);

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d    = op;
                    acc_d   = {{XLEN{1'b0}}, in1};
                    opb_d   = in2;
                    state_d = PREP;
                end
            end
            PREP: begin
                cnt_d   = '0;
                acc_d   = {{XLEN{1'b0}}, neg_a[XLEN-1:0]};
                opb_d   = neg_b[XLEN-1:0];
                neg_d   = (op_q == OP_REM) ? sgn_a : (sgn_a ^ sgn_b);
                state_d = CALC;
                if (is_div && (opb_q == '0)) begin
                    result_d = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : acc_q[XLEN-1:0];
                    state_d  = DONE;
                end else if (((op_q == OP_DIV) || (op_q == OP_REM)) &&
                             (acc_q[XLEN-1:0] == {1'b1, {(XLEN-1){1'b0}}}) && (opb_q == '1)) begin
                    result_d = (op_q == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
                    state_d  = DONE;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (is_div) begin
                    acc_d = addsub[XLEN] ? {r33[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                         : {addsub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = acc_q[0] ? {addsub, acc_q[XLEN-1:1]}
                                     : {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1:1]};
                end
                if (cnt_q == 5'(MD_ITERS - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                case (op_q)
                    OP_MUL:                       result_d = prod_fix[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:              result_d = quo_fix[XLEN-1:0];
                    default:                      result_d = rem_fix[XLEN-1:0];
                endcase
                state_d = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    assign unused_bits = ^{neg_a[2*XLEN-1:XLEN], neg_b[2*XLEN-1:XLEN],
                           quo_fix[2*XLEN-1:XLEN], rem_fix[2*XLEN-1:XLEN]};

    assign req_ready   = rst_n && (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign resp_valid  = (state_q == DONE);
    assign resp_result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M cases, handshake/flush/reset corners, random ops.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] sb_res[$];
    string       sb_tag[$];

    muldiv_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .in1        (in1),
        .in2        (in2),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: RV32M semantics via 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0] ua, ub, up;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            OP_MUL:    begin up = ua * ub; return up[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
            OP_MULHU:  begin up = ua * ub; return up[63:32]; end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            OP_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            OP_REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default:   begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int exp_cycle(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 2;
        if ((f == OP_DIV || f == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Compare at the handshake: the negedge before the edge that consumes the result.
    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            chk("sb_depth", 32'(sb_res.size()), 32'd1);
            if (sb_res.size() > 0) begin
                chk(sb_tag.pop_front(), resp_result, sb_res.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int w = 0;
        while (!req_ready && w < 50) begin tick(); w++; end
        chk("ready_wait", 32'(req_ready), 32'd1);
    endtask

    // Returns after the accept edge, i.e. in cycle T+1.
    task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        wait_ready();
        req_valid = 1'b1; op = f; in1 = a; in2 = b;
        sb_res.push_back(exp);
        sb_tag.push_back(tag);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_exp, input int hold);
        int lat = 1;
        issue(tag, f, a, b, exp);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        while (!resp_valid && lat < 100) begin tick(); lat++; end
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        if (!resp_valid) begin
            void'(sb_res.pop_front());
            void'(sb_tag.pop_front());
            return;
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "_hold_result"}, resp_result, exp);
            chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic run_ref(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        run_op(tag, f, a, b, ref_md(f, a, b), exp_cycle(f, a, b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        rst_n = 1'b0; req_valid = 1'b0; op = '0; in1 = '0; in2 = '0;
        flush = 1'b0; resp_ready = 1'b0;
        repeat (3) tick();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_result", resp_result, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", 32'(req_ready), 32'd1);

        run_op("mul_7_m3",      OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 0);
        run_op("mulhu_max",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 3);
        run_op("div_m7_2",      OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35, 0);
        run_op("rem_m7_2",      OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35, 0);
        run_op("mulhsu_m1_2",   OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 35, 0);
        run_op("divu_by0",      OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 2,  0);
        run_op("rem_by0",       OP_REM,    32'd5,          32'd0,         32'd5,         2,  0);
        run_op("div_ovf",       OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  0);
        run_op("rem_ovf",       OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2,  0);
        run_op("mulh_m2_3",     OP_MULH,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 35, 0);
        run_op("remu_big",      OP_REMU,   32'hFFFF_FFFF,  32'h8000_0001, 32'h7FFF_FFFE, 35, 0);

        // Flush in IDLE must block the accept.
        req_valid = 1'b1; op = OP_MUL; in1 = 32'd2; in2 = 32'd2; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", 32'(busy), 32'd0);

        // Flush during CALC: killed op yields no response.
        issue("flushed", OP_MUL, 32'd1234, 32'd5678, 32'd0);
        repeat (9) tick();
        chk("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_req_ready", 32'(req_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        void'(sb_res.pop_front());
        void'(sb_tag.pop_front());
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        chk("flush_no_resp", 32'(seen), 32'd0);
        run_op("mul_3_4", OP_MUL, 32'd3, 32'd4, 32'd12, 35, 0);

        // Reset mid-operation.
        issue("reset_killed", OP_DIVU, 32'd1000, 32'd3, 32'd333);
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        chk("midrst_result", resp_result, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        void'(sb_res.pop_front());
        void'(sb_tag.pop_front());
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_ready", 32'(req_ready), 32'd1);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 35, 0);

        for (int i = 0; i < 16; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            rb = (i % 5 == 4) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
            run_ref($sformatf("rand%0d_op%0d", i, rf), rf, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
